// File: rtl/video_timing_meter.sv
`default_nettype none
// ============================================================================
// Module   : video_timing_meter
// Brief    : Passive raster meter. Infers sync polarity and measures line and
//            frame totals, active extents and sync lengths, publishing them
//            once per frame. Optional CRC-16 of active pixels when
//            VIDEO_METER_CRC_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module video_timing_meter #(
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce_pix,
    input  logic             h_sync,
    input  logic             v_sync,
    input  logic             de,
    input  logic [7:0]       r,
    input  logic [7:0]       g,
    input  logic [7:0]       b,
    output logic [CNT_W-1:0] h_total,
    output logic [CNT_W-1:0] h_active,
    output logic [CNT_W-1:0] h_sync_len,
    output logic [CNT_W-1:0] v_total,
    output logic [CNT_W-1:0] v_active,
    output logic [CNT_W-1:0] v_sync_len,
    output logic             hs_pol,
    output logic             vs_pol,
    output logic             frame_stb,
    output logic             meas_valid,
    output logic             stable,
    output logic [15:0]      crc
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == C_CNT_MAX) ? v : v + C_CNT_ONE;
    endfunction

    logic             r_hs_pol, r_vs_pol;
    logic             r_hs_a_prev, r_vs_a_ls, r_armed, r_line_had_de;
    logic [CNT_W-1:0] r_hc, r_hsc, r_hac, r_vc, r_vsc, r_vac;
    logic [CNT_W-1:0] r_h_total, r_h_active, r_h_sync_len;
    logic [CNT_W-1:0] r_v_total, r_v_active, r_v_sync_len;
    logic             r_pub_hs_pol, r_pub_vs_pol;
    logic             r_frame_stb, r_meas_valid, r_stable;

    logic             w_hs_a, w_vs_a, w_line_start, w_frame_start;
    logic             w_hs_pol_nxt, w_vs_pol_nxt, w_same, w_crc_same;
    logic [CNT_W-1:0] w_vac_done;

    assign w_hs_a        = r_hs_pol ? h_sync : ~h_sync;
    assign w_vs_a        = r_vs_pol ? v_sync : ~v_sync;
    assign w_line_start  = w_hs_a & ~r_hs_a_prev;
    assign w_frame_start = w_line_start & w_vs_a & ~r_vs_a_ls;
    assign w_hs_pol_nxt  = de ? ~h_sync : r_hs_pol;
    assign w_vs_pol_nxt  = de ? ~v_sync : r_vs_pol;
    // Line that is completing at this line start still counts toward v_active
    assign w_vac_done    = r_line_had_de ? sat_inc(r_vac) : r_vac;

    assign w_same = (r_hc == r_h_total) && (r_hac == r_h_active) &&
                    (r_hsc == r_h_sync_len) && (r_vc == r_v_total) &&
                    (w_vac_done == r_v_active) && (r_vsc == r_v_sync_len) &&
                    (w_hs_pol_nxt == r_pub_hs_pol) && (w_vs_pol_nxt == r_pub_vs_pol) &&
                    w_crc_same;

`ifdef VIDEO_METER_CRC_EN
    function automatic logic [15:0] crc16_24(input logic [15:0] c, input logic [23:0] d);
        logic [15:0] x;
        x = c;
        for (int i = 23; i >= 0; i--) begin
            x = {x[14:0], 1'b0} ^ ((x[15] ^ d[i]) ? 16'h1021 : 16'h0000);
        end
        return x;
    endfunction

    logic [15:0] r_crc_run, r_crc_pub;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_crc_run <= 16'hFFFF;
            r_crc_pub <= 16'h0000;
        end else if (ce_pix) begin
            if (w_frame_start) begin
                if (r_armed) r_crc_pub <= r_crc_run;
                r_crc_run <= de ? crc16_24(16'hFFFF, {r, g, b}) : 16'hFFFF;
            end else if (de) begin
                r_crc_run <= crc16_24(r_crc_run, {r, g, b});
            end
        end
    end

    assign w_crc_same = (r_crc_run == r_crc_pub);
    assign crc        = r_crc_pub;
`else
    logic w_unused_rgb;
    assign w_unused_rgb = ^{r, g, b};
    assign w_crc_same   = 1'b1;
    assign crc          = 16'h0000;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hs_pol      <= 1'b0;
            r_vs_pol      <= 1'b0;
            r_hs_a_prev   <= 1'b0;
            r_vs_a_ls     <= 1'b0;
            r_armed       <= 1'b0;
            r_line_had_de <= 1'b0;
            r_hc          <= '0;
            r_hsc         <= '0;
            r_hac         <= '0;
            r_vc          <= '0;
            r_vsc         <= '0;
            r_vac         <= '0;
            r_h_total     <= '0;
            r_h_active    <= '0;
            r_h_sync_len  <= '0;
            r_v_total     <= '0;
            r_v_active    <= '0;
            r_v_sync_len  <= '0;
            r_pub_hs_pol  <= 1'b0;
            r_pub_vs_pol  <= 1'b0;
            r_frame_stb   <= 1'b0;
            r_meas_valid  <= 1'b0;
            r_stable      <= 1'b0;
        end else begin
            r_frame_stb <= 1'b0;
            if (ce_pix) begin
                r_hs_a_prev <= w_hs_a;
                r_hs_pol    <= w_hs_pol_nxt;
                r_vs_pol    <= w_vs_pol_nxt;
                if (w_line_start) begin
                    // Current sample is the first of the new line
                    r_hc          <= C_CNT_ONE;
                    r_hsc         <= C_CNT_ONE;
                    r_hac         <= {{(CNT_W-1){1'b0}}, de};
                    r_line_had_de <= de;
                    r_vs_a_ls     <= w_vs_a;
                    if (w_frame_start) begin
                        r_vc    <= C_CNT_ONE;
                        r_vsc   <= C_CNT_ONE;
                        r_vac   <= '0;
                        r_armed <= 1'b1;
                        if (r_armed) begin
                            r_h_total    <= r_hc;
                            r_h_active   <= r_hac;
                            r_h_sync_len <= r_hsc;
                            r_v_total    <= r_vc;
                            r_v_active   <= w_vac_done;
                            r_v_sync_len <= r_vsc;
                            r_pub_hs_pol <= w_hs_pol_nxt;
                            r_pub_vs_pol <= w_vs_pol_nxt;
                            r_stable     <= w_same;
                            r_frame_stb  <= 1'b1;
                            r_meas_valid <= 1'b1;
                        end
                    end else begin
                        r_vc  <= sat_inc(r_vc);
                        r_vac <= w_vac_done;
                        if (w_vs_a) r_vsc <= sat_inc(r_vsc);
                    end
                end else begin
                    r_hc <= sat_inc(r_hc);
                    if (w_hs_a) r_hsc <= sat_inc(r_hsc);
                    if (de) begin
                        r_hac         <= sat_inc(r_hac);
                        r_line_had_de <= 1'b1;
                    end
                end
            end
        end
    end

    assign h_total    = r_h_total;
    assign h_active   = r_h_active;
    assign h_sync_len = r_h_sync_len;
    assign v_total    = r_v_total;
    assign v_active   = r_v_active;
    assign v_sync_len = r_v_sync_len;
    assign hs_pol     = r_hs_pol;
    assign vs_pol     = r_vs_pol;
    assign frame_stb  = r_frame_stb;
    assign meas_valid = r_meas_valid;
    assign stable     = r_stable;

endmodule
`default_nettype wire

// File: tb/tb_video_timing_meter.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_timing_meter
// Brief    : Self-checking bench for video_timing_meter; frame expectations are
//            queued as each frame starts and popped on frame_stb.
// Revision : 1.0 - initial release
// ============================================================================
module tb_video_timing_meter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        ce_pix = 1'b0, h_sync = 1'b1, v_sync = 1'b1, de = 1'b0;
    logic [7:0]  r = '0, g = '0, b = '0;
    logic [11:0] h_total, h_active, h_sync_len, v_total, v_active, v_sync_len;
    logic        hs_pol, vs_pol, frame_stb, meas_valid, stable;
    logic [15:0] crc;

    logic        ce8 = 1'b0, hs8 = 1'b1, vs8 = 1'b1, de8 = 1'b0;
    logic [7:0]  rgb8 = '0;
    logic [7:0]  h_total8, h_active8, h_sync_len8, v_total8, v_active8, v_sync_len8;
    logic        hs_pol8, vs_pol8, frame_stb8, meas_valid8, stable8;
    logic [15:0] crc8;

    video_timing_meter #(.CNT_W(12)) dut (
        .clk(clk), .reset(reset), .ce_pix(ce_pix), .h_sync(h_sync), .v_sync(v_sync),
        .de(de), .r(r), .g(g), .b(b),
        .h_total(h_total), .h_active(h_active), .h_sync_len(h_sync_len),
        .v_total(v_total), .v_active(v_active), .v_sync_len(v_sync_len),
        .hs_pol(hs_pol), .vs_pol(vs_pol), .frame_stb(frame_stb),
        .meas_valid(meas_valid), .stable(stable), .crc(crc)
    );

    video_timing_meter #(.CNT_W(8)) dut8 (
        .clk(clk), .reset(reset), .ce_pix(ce8), .h_sync(hs8), .v_sync(vs8),
        .de(de8), .r(rgb8), .g(rgb8), .b(rgb8),
        .h_total(h_total8), .h_active(h_active8), .h_sync_len(h_sync_len8),
        .v_total(v_total8), .v_active(v_active8), .v_sync_len(v_sync_len8),
        .hs_pol(hs_pol8), .vs_pol(vs_pol8), .frame_stb(frame_stb8),
        .meas_valid(meas_valid8), .stable(stable8), .crc(crc8)
    );

    typedef struct {
        bit          skip;
        logic [11:0] vt;
        logic        pol;
        logic [15:0] crc;
        logic        stab;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad = 0;
    bit          stb_prev = 1'b0;

    bit          armed, prev_valid, junk_next;
    logic [11:0] prev_vt, cur_vt;
    logic        prev_pol, cur_pol;
    logic [15:0] prev_crc, crc_model;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, want);
        end
    endtask

    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] x;
        x = c;
        for (int i = 0; i < 8; i++)
            x = (x[15] ^ d[7-i]) ? ((x << 1) ^ 16'h1021) : (x << 1);
        return x;
    endfunction

    task automatic push_expect();
        exp_t e;
        e.skip = junk_next;
        e.vt   = cur_vt;
        e.pol  = cur_pol;
`ifdef VIDEO_METER_CRC_EN
        e.crc  = crc_model;
`else
        e.crc  = 16'h0000;
`endif
        e.stab = prev_valid && (e.vt == prev_vt) && (e.pol == prev_pol) && (e.crc == prev_crc);
        if (junk_next) begin
            prev_valid = 1'b0;
        end else begin
            prev_valid = 1'b1;
            prev_vt    = e.vt;
            prev_pol   = e.pol;
            prev_crc   = e.crc;
        end
        junk_next = 1'b0;
        sb_q.push_back(e);
    endtask

    task automatic drive_px(input logic hs, input logic vs, input logic d,
                            input logic [7:0] pr, input logic [7:0] pg, input logic [7:0] pb);
        @(posedge clk); #1;
        h_sync = hs; v_sync = vs; de = d; r = pr; g = pg; b = pb; ce_pix = 1'b1;
        @(posedge clk); #1;
        ce_pix = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    // Line: sync 0-2, porch 3-4, active 5-16, porch 17-19. Frame: vsync lines 0-1, last 6 lines active.
    task automatic run_frame(input int lines, input bit inv, input bit modpx, input int stop);
        bit         act;
        logic [7:0] pr, pg, pb;
        for (int l = 0; l < stop; l++) begin
            for (int p = 0; p < 20; p++) begin
                if (l == 0 && p == 0) begin
                    if (armed) push_expect();
                    armed     = 1'b1;
                    crc_model = 16'hFFFF;
                    cur_vt    = 12'(lines);
                    cur_pol   = inv;
                end
                act = (l >= lines - 6) && (p >= 5) && (p < 17);
                pr  = act ? 8'h12 : 8'h00;
                pg  = act ? 8'h34 : 8'h00;
                pb  = act ? 8'h56 : 8'h00;
                if (modpx && act && l == lines - 3 && p == 9) pr = pr ^ 8'h01;
                if (act) crc_model = crc_byte(crc_byte(crc_byte(crc_model, pr), pg), pb);
                drive_px(inv ? (p < 3) : !(p < 3), inv ? (l < 2) : !(l < 2), act, pr, pg, pb);
            end
        end
    endtask

    task automatic apply_reset(input string tag);
        @(posedge clk); #1;
        reset = 1'b1;
        #2;
        check({tag, "_h_total"}, 32'(h_total), 0);
        check({tag, "_h_active"}, 32'(h_active), 0);
        check({tag, "_h_sync_len"}, 32'(h_sync_len), 0);
        check({tag, "_v_total"}, 32'(v_total), 0);
        check({tag, "_v_active"}, 32'(v_active), 0);
        check({tag, "_v_sync_len"}, 32'(v_sync_len), 0);
        check({tag, "_pols"}, 32'({hs_pol, vs_pol}), 0);
        check({tag, "_flags"}, 32'({frame_stb, meas_valid, stable}), 0);
        check({tag, "_crc"}, 32'(crc), 0);
        @(posedge clk); #1;
        reset      = 1'b0;
        armed      = 1'b0;
        junk_next  = 1'b0;
        prev_valid = 1'b1;
        prev_vt    = '0;
        prev_pol   = 1'b0;
        prev_crc   = 16'h0000;
    endtask

    task automatic drive8(input logic hs, input logic vs, input logic d);
        @(posedge clk); #1;
        hs8 = hs; vs8 = vs; de8 = d; ce8 = 1'b1;
    endtask

    always @(negedge clk) begin
        if (frame_stb) begin
            check("stb_single_cycle", 32'(stb_prev), 0);
            if (sb_q.size() == 0) begin
                check("stb_unexpected", 32'(frame_stb), 0);
            end else begin
                mon_e = sb_q.pop_front();
                check("meas_valid", 32'(meas_valid), 1);
                if (!mon_e.skip) begin
                    check("h_total", 32'(h_total), 20);
                    check("h_active", 32'(h_active), 12);
                    check("h_sync_len", 32'(h_sync_len), 3);
                    check("v_total", 32'(v_total), 32'(mon_e.vt));
                    check("v_active", 32'(v_active), 6);
                    check("v_sync_len", 32'(v_sync_len), 2);
                    check("hs_pol", 32'(hs_pol), 32'(mon_e.pol));
                    check("vs_pol", 32'(vs_pol), 32'(mon_e.pol));
                    check("crc", 32'(crc), 32'(mon_e.crc));
                    check("stable", 32'(stable), 32'(mon_e.stab));
                end
            end
        end
        stb_prev = frame_stb;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        apply_reset("rst0");

        // Active-low raster; 12-line frames in the middle; one altered pixel near the end
        run_frame(10, 0, 0, 10);
        run_frame(10, 0, 0, 10);
        run_frame(10, 0, 0, 10);
        run_frame(12, 0, 0, 12);
        run_frame(12, 0, 0, 12);
        run_frame(10, 0, 0, 10);
        run_frame(10, 0, 1, 10);
        run_frame(10, 0, 0, 10);
        repeat (8) @(posedge clk);
        check("sb_empty_s1", 32'(sb_q.size()), 0);

        // Inverted syncs: first publish spans the polarity-learning interval
        apply_reset("rst1");
        junk_next = 1'b1;
        for (int i = 0; i < 4; i++) run_frame(10, 1, 0, 10);
        repeat (8) @(posedge clk);
        check("sb_empty_s2", 32'(sb_q.size()), 0);

        // Reset in the middle of frame 2
        apply_reset("rst2");
        run_frame(10, 0, 0, 10);
        run_frame(10, 0, 0, 5);
        check("valid_before_mid_reset", 32'(meas_valid), 1);
        check("sb_empty_s3a", 32'(sb_q.size()), 0);
        apply_reset("mid");
        run_frame(10, 0, 0, 10);
        check("valid_after_one_fs", 32'(meas_valid), 0);
        run_frame(10, 0, 0, 10);
        run_frame(10, 0, 0, 10);
        repeat (8) @(posedge clk);
        check("sb_empty_s3b", 32'(sb_q.size()), 0);

        // 8-bit counters, continuous ce_pix, 300-sample line saturates h_total
        drive8(1'b0, 1'b0, 1'b0);
        drive8(1'b1, 1'b1, 1'b0);
        drive8(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 299; i++) drive8(1'b1, 1'b1, i < 200);
        drive8(1'b0, 1'b0, 1'b0);
        drive8(1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check("sat_stb", 32'(frame_stb8), 1);
        check("sat_h_total", 32'(h_total8), 255);
        check("sat_h_active", 32'(h_active8), 200);
        check("sat_h_sync_len", 32'(h_sync_len8), 1);
        check("sat_v_total", 32'(v_total8), 2);
        check("sat_v_active", 32'(v_active8), 1);
        check("sat_v_sync_len", 32'(v_sync_len8), 1);
        check("sat_valid", 32'(meas_valid8), 1);
        check("sat_stable", 32'(stable8), 0);
        drive8(1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check("sat_stb_low", 32'(frame_stb8), 0);
        ce8 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/video_timing_meter.md
# video_timing_meter

Passive measurement block on the suite's video output (the receiving end of `ce_pix`/`h_sync`/`v_sync`/`de`/RGB). It infers sync polarity and measures horizontal and vertical totals, active widths and sync lengths. All measurements are published coherently once per frame, so a bench, or an OSD/debug readout, can confirm that each test pattern mode emits the intended raster.

## Interface
Parameters:
- `CNT_W`, default 12: width of all pixel and line counters and measurement outputs. Counters saturate at all-ones.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `ce_pix`  in  1  pixel enable. All video inputs are sampled only when it is high.
- `h_sync`, `v_sync`  in  1  sync inputs, either polarity.
- `de`  in  1  display enable.
- `r`, `g`, `b`  in  8  pixel data.
- `h_total`, `h_active`, `h_sync_len`  out  CNT_W  pixel counts per line.
- `v_total`, `v_active`, `v_sync_len`  out  CNT_W  line counts per frame.
- `hs_pol`, `vs_pol`  out  1  1 = active-high sync.
- `frame_stb`  out  1  one-clock pulse when the outputs are republished.
- `meas_valid`  out  1  outputs hold a full frame's measurement.
- `stable`  out  1  the last two published frames are identical.
- `crc`  out  16  frame pixel CRC. Constant 0 when the CRC feature is not compiled in (see Configuration).

## Operation
- Sample: one `clk` cycle with `ce_pix`=1. All state advances only on samples, except reset.
- Polarity: on every sample with `de`=1, `hs_pol` ← ~`h_sync` and `vs_pol` ← ~`v_sync`.
- Normalized syncs: `hs_a` = `hs_pol` ? `h_sync` : ~`h_sync`; `vs_a` is formed the same way.
- Line start: a sample where `hs_a`=1 and the previous sample's `hs_a`=0.
- Horizontal working counters `hc`, `hsc`, `hac`:
  - Each sample increments `hc`, increments `hsc` if `hs_a`=1, and increments `hac` if `de`=1.
  - At a line start the counters are copied to line shadows and restart at 1 / (`hs_a`) / (`de`), i.e. the current sample counts toward the new line.
  - `line_had_de` is set by any `de` sample in the line.
- Vertical working counters, updated at line starts only:
  - `vc` counts lines.
  - `vsc` counts line starts with `vs_a`=1.
  - `vac` counts completed lines whose `line_had_de`=1.
- Frame start: a line start where `vs_a`=1 and `vs_a` at the previous line start was 0.
- At frame start:
  - If a previous frame start has occurred since reset, publish the line shadows (last complete line) plus `vc`/`vsc`/`vac` to the outputs, pulse `frame_stb`, and set `meas_valid`.
  - Otherwise only arm.
  - In either case, restart the vertical counters.
- `stable` ← 1 when the newly published six counts and both polarities equal the previous published set; otherwise ← 0. `stable` changes only at publish.
- Saturation: any counter reaching 2^CNT_W−1 holds there; the published value is then all-ones.
- Simultaneous events: a line start and frame start in the same sample are handled as one publish. Line shadows are captured before vertical publish, so the published horizontal values belong to the last line of the ending frame.

## Timing
- Reset values:
  - All measurement outputs, `crc`, `frame_stb`, `meas_valid`, `stable`, `hs_pol`, `vs_pol` = 0.
  - Previous-sample history = 0.
- Latency: outputs and `frame_stb` are registered; they change on the clock edge immediately following the frame-start sample.
- `frame_stb` is high for exactly one `clk` cycle, even when `ce_pix` stays high.
- `meas_valid` first rises with the second frame start after reset and stays high until reset.
- Reset mid-frame: everything returns to reset values immediately (asynchronous); two further frame starts are needed for `meas_valid`.

## Configuration
- `VIDEO_METER_CRC_EN` defined:
  - Each `de` sample feeds bytes r, g, b (MSB first, in that order) into a CRC-16-CCITT (polynomial 0x1021, init 0xFFFF), 24 bits per clock.
  - The running CRC is published to `crc` at frame start and reinitialized to 0xFFFF.
  - `crc` participates in the `stable` comparison.
- Undefined: no CRC logic; `crc` is tied to 0.

## Test plan
- Active-low syncs, `ce_pix` every 4th clock: line 20 px (active 12, hsync 3), frame 10 lines (active 6, vsync 2), 3 frames → after frame start 2: `h_total`=20, `h_active`=12, `h_sync_len`=3, `v_total`=10, `v_active`=6, `v_sync_len`=2, `hs_pol`=`vs_pol`=0, `meas_valid`=1; `stable`=1 after frame start 3.
- Same raster with both syncs inverted → `hs_pol`=`vs_pol`=1 and identical counts.
- Change the frame to 12 lines for one frame → publish shows `v_total`=12 with `stable`=0; the next identical frame gives `stable`=1.
- Assert `reset` mid-frame 2 → all outputs 0 at once; `meas_valid` returns only at the second subsequent frame start.
- `CNT_W`=8, hsync held inactive for 300 samples, then a line start → published `h_total`=255.
- With `VIDEO_METER_CRC_EN`, a constant-color frame → `crc` equals the bench CRC-16-CCITT model value over the active pixels; changing one pixel changes `crc` and clears `stable`.
